// File: rtl/kernel_rx_parser.sv
// Parses ASCII decimal kernel entries from a UART byte stream into a 3x3 kernel.
// The published kernel updates only when all nine entries have been received.
module kernel_rx_parser #(
  parameter int         MAX_VAL    = 255,
  parameter logic [7:0] RST_CENTER = 8'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         load_en,
  output logic [199:0] kernel_flat,
  output logic         kernel_valid,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [3:0]   entry_cnt,
  output logic         load_busy
);

  typedef enum logic [1:0] {S_IDLE, S_NUM, S_ERR} state_e;

  localparam logic [9:0]  MAX_ACC     = 10'(MAX_VAL);
  localparam logic [13:0] ACC_SAT     = 14'd1023;
  localparam logic [1:0]  ERR_ILLEGAL = 2'd1;
  localparam logic [1:0]  ERR_RANGE   = 2'd2;
  localparam logic [7:0]  CH_LF       = 8'h0A;

  state_e           state_q, state_d;
  logic [9:0]       acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [8:0][7:0]  shadow_q, shadow_d;
  logic [8:0][7:0]  kernel_q, kernel_d;
  logic             kvalid_q, kvalid_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic        accept, is_digit, is_sep, raise_err;
  logic [1:0]  cause;
  logic [3:0]  digit_val;
  logic [13:0] acc_mul;
  logic [9:0]  acc_sat;

  assign accept    = rx_valid && load_en;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep    = (rx_data == 8'h20) || (rx_data == 8'h2C) || (rx_data == 8'h09) ||
                     (rx_data == 8'h0D) || (rx_data == CH_LF);
  assign digit_val = rx_data[3:0];
  // Wide product so that long digit runs clamp at 1023 instead of wrapping.
  assign acc_mul   = 14'(acc_q) * 14'd10 + 14'(digit_val);
  assign acc_sat   = (acc_mul > ACC_SAT) ? 10'd1023 : acc_mul[9:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    kernel_d  = kernel_q;
    kvalid_d  = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    raise_err = 1'b0;
    cause     = ERR_ILLEGAL;

    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            acc_d   = 10'(digit_val);
            state_d = S_NUM;
          end else if (!is_sep) begin
            raise_err = 1'b1;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            acc_d = acc_sat;
          end else if (is_sep) begin
            if (acc_q > MAX_ACC) begin
              raise_err = 1'b1;
              cause     = ERR_RANGE;
            end else begin
              state_d = S_IDLE;
              acc_d   = '0;
              if (cnt_q == 4'd8) begin
                kernel_d    = shadow_q;
                kernel_d[8] = acc_q[7:0];
                kvalid_d    = 1'b1;
                cnt_d       = '0;
              end else begin
                shadow_d[cnt_q] = acc_q[7:0];
                cnt_d           = cnt_q + 4'd1;
              end
            end
          end else begin
            raise_err = 1'b1;
          end
        end
        S_ERR: begin
          if (rx_data == CH_LF) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (raise_err) begin
        err_d    = 1'b1;
        code_d   = cause;
        cnt_d    = '0;
        acc_d    = '0;
        shadow_d = '0;
        // An overflow committed by LF has already reached end of line.
        state_d  = (rx_data == CH_LF) ? S_IDLE : S_ERR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      // NOTE: the shadow array is reset too, since partial kernels must not survive a reset.
      shadow_q    <= '0;
      kernel_q    <= '0;
      kernel_q[4] <= RST_CENTER;
      kvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      kernel_q <= kernel_d;
      kvalid_q <= kvalid_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign kernel_flat  = {128'd0, kernel_q};
  assign kernel_valid = kvalid_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign entry_cnt    = cnt_q;
  assign load_busy    = (cnt_q != 4'd0) || (state_q == S_NUM);

endmodule

// File: tb/tb_kernel_rx_parser.sv
// Scoreboard bench for kernel_rx_parser: expected kernels and error codes are queued
// as stimulus is sent and matched against kernel_valid / err pulses.
module tb_kernel_rx_parser;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         load_en;
  logic [199:0] kernel_flat;
  logic         kernel_valid;
  logic         err;
  logic [1:0]   err_code;
  logic [3:0]   entry_cnt;
  logic         load_busy;

  localparam logic [71:0] K_IDENT = 72'h00_0000_0001_0000_0000;

  int n_checks = 0;
  int n_errors = 0;
  logic [71:0] exp_k_q[$];
  logic [1:0]  exp_e_q[$];
  logic [71:0] exp_flat = K_IDENT;

  kernel_rx_parser #(.MAX_VAL(255), .RST_CENTER(8'd1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .load_en(load_en), .kernel_flat(kernel_flat), .kernel_valid(kernel_valid),
    .err(err), .err_code(err_code), .entry_cnt(entry_cnt), .load_busy(load_busy)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every published kernel or error pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kernel_valid && err) begin
        n_checks++; n_errors++;
        $display("FAIL excl: kernel_valid and err both high at %0t", $time);
      end
      if (kernel_valid) begin
        n_checks++;
        if (exp_k_q.size() == 0) begin
          n_errors++;
          $display("FAIL kernel_unexp: got %h, expected no kernel_valid", kernel_flat[71:0]);
        end else begin
          logic [71:0] e;
          e = exp_k_q.pop_front();
          exp_flat = e;
          if (kernel_flat !== {128'd0, e}) begin
            n_errors++;
            $display("FAIL kernel: got %h, expected %h", kernel_flat, {128'd0, e});
          end
        end
      end
      if (err) begin
        n_checks++;
        if (exp_e_q.size() == 0) begin
          n_errors++;
          $display("FAIL err_unexp: got err_code %0d, expected no err", err_code);
        end else begin
          logic [1:0] c;
          c = exp_e_q.pop_front();
          if (err_code !== c) begin
            n_errors++;
            $display("FAIL err_code: got %0d, expected %0d", err_code, c);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_k_q.size() != 0 || exp_e_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_pending: got %0d kernels / %0d errs outstanding, expected 0 / 0",
               tag, exp_k_q.size(), exp_e_q.size());
      exp_k_q.delete();
      exp_e_q.delete();
    end
    n_checks++;
    if (kernel_flat !== {128'd0, exp_flat}) begin
      n_errors++;
      $display("FAIL %s_flat: got %h, expected %h", tag, kernel_flat[71:0], exp_flat);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] c, input logic busy);
    n_checks++;
    if (entry_cnt !== c || load_busy !== busy) begin
      n_errors++;
      $display("FAIL %s: got entry_cnt=%0d load_busy=%b, expected %0d %b",
               tag, entry_cnt, load_busy, c, busy);
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    if (kernel_flat !== {128'd0, K_IDENT} || kernel_valid !== 1'b0 || err !== 1'b0 ||
        err_code !== 2'd0 || entry_cnt !== 4'd0 || load_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got flat=%h kv=%b err=%b code=%0d cnt=%0d busy=%b, expected identity/0",
               tag, kernel_flat, kernel_valid, err, err_code, entry_cnt, load_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; load_en = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    exp_flat = K_IDENT;
  endtask

  task automatic test_basic();
    exp_k_q.push_back(72'h09_0807_0605_0403_0201);
    send_str("1 2 3 ");
    check_cnt("basic_cnt3", 4'd3, 1'b1);
    send_str("4");
    check_cnt("basic_num", 4'd3, 1'b1);
    send_str(" 5 6 7 8 9\n");
    drain("basic");
    check_cnt("basic_cnt0", 4'd0, 1'b0);
  endtask

  task automatic test_separators();
    exp_k_q.push_back(72'h07_00FF_0605_0403_0201);
    send_str("1,2,3\n4 5 6\r\n255 0 007 ");
    drain("seps");
    n_checks++;
    if (err_code !== 2'd0) begin
      n_errors++;
      $display("FAIL seps_code: got %0d, expected 0", err_code);
    end
  endtask

  task automatic test_overflow();
    exp_e_q.push_back(2'd2);
    send_str("1 2 256 ");
    drain("ovf");
    check_cnt("ovf_cnt", 4'd0, 1'b0);
    send_str("5 ");
    check_cnt("ovf_discard", 4'd0, 1'b0);
    send_str("\n");
    exp_k_q.push_back({9{8'h09}});
    send_str("9 9 9 9 9 9 9 9 9 ");
    drain("ovf_nines");
  endtask

  task automatic test_saturation();
    // 1024 wraps to 0 in a 10-bit accumulator; it must clamp and fail the range check.
    exp_e_q.push_back(2'd2);
    send_str("1024 ");
    drain("sat");
    send_str("\n");
  endtask

  task automatic test_illegal();
    exp_e_q.push_back(2'd1);
    send_str("1 2 x 3 4 5 6 7 8 9 ");
    drain("illegal");
    check_cnt("illegal_cnt", 4'd0, 1'b0);
    n_checks++;
    if (err_code !== 2'd1) begin
      n_errors++;
      $display("FAIL illegal_hold: got %0d, expected 1", err_code);
    end
    send_str("\n");
  endtask

  task automatic test_lf_overflow();
    exp_e_q.push_back(2'd2);
    send_str("300\n");
    drain("lf_ovf");
    send_str("5 ");
    check_cnt("lf_ovf_idle", 4'd1, 1'b1);
    send_str("\n");
  endtask

  task automatic test_load_en();
    // Clear the single leftover entry so this kernel starts fresh.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_flat = K_IDENT;
    exp_k_q.push_back(72'h09_0807_0605_0403_0201);
    send_str("1 2 3");
    load_en = 1'b0;
    send_str("9 9 9");
    check_cnt("hold", 4'd2, 1'b1);
    load_en = 1'b1;
    send_str(" 4 5 6 7 8 9 ");
    drain("load_en");
  endtask

  task automatic test_reset_mid();
    send_str("1 2 3 4 ");
    check_cnt("mid_cnt", 4'd4, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("reset_async");
    @(negedge clk); rst_n = 1'b1;
    exp_flat = K_IDENT;
    exp_k_q.push_back(72'h01_0203_0405_0607_0809);
    send_str("9 8 7 6 5 4 3 2 1\n");
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    exp_k_q.push_back({9{8'h01}});
    exp_k_q.push_back({9{8'h02}});
    send_str("1 1 1 1 1 1 1 1 1 2 2 2 2 2 2 2 2 2 ");
    drain("b2b");
    check_cnt("b2b_cnt", 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_separators();
    test_overflow();
    test_saturation();
    test_illegal();
    test_lf_overflow();
    test_load_en();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
